one_sixteen_demux: RTL and testbench
====================================

ONE_SIXTEEN_DEMUX -- requirements
Module: one_sixteen_demux

Interface
REQ-001 SHALL have parameter CLEAR_ON_START, default 1, meaning op is zeroed on the cycle a frame starts.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port din, input, 1, data bit to be routed.
REQ-005 SHALL have port s, input, 4, destination index in addressed mode.
REQ-006 SHALL have port wr_en, input, 1, write strobe; din is valid when high.
REQ-007 SHALL have port mode, input, 1, with 0 meaning addressed and 1 meaning auto-sequenced.
REQ-008 SHALL have port start, input, 1, frame-start pulse used in auto mode.
REQ-009 SHALL have port op, output, 16, the registered demultiplexed outputs.
REQ-010 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-011 SHALL have port frame_done, output, 1, a one-cycle pulse after the sixteenth bit is written.
REQ-012 SHALL have port idx, output, 4, the current auto-sequence write index.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD and DONE.
REQ-014 SHALL, in IDLE with mode=0 and wr_en=1, set op[s] to din at the next clk edge; the other 15 bits hold; latency 1 cycle.
REQ-015 SHALL, in IDLE with wr_en=0, hold all op bits.
REQ-016 SHALL, in IDLE with mode=1 and start=1, go to LOAD and set idx=0; if CLEAR_ON_START=1, set op=0 on the same edge.
REQ-017 SHALL write nothing to op from din on the start cycle, even when wr_en=1 (start wins).
REQ-018 SHALL ignore start when mode=0, and ignore wr_en in IDLE when mode=1.
REQ-019 SHALL, in LOAD with wr_en=1, set op[idx] to din and increment idx modulo 16.
REQ-020 SHALL, in LOAD with wr_en=0, stall: idx and op hold.
REQ-021 SHALL, when the write at idx=15 completes in LOAD, go to DONE with idx wrapping to 0.
REQ-022 SHALL, in DONE, assert frame_done for exactly one cycle and then return to IDLE unconditionally.
REQ-023 SHALL, in LOAD and DONE, ignore s, mode, start and wr_en except as stated in REQ-019 to REQ-021.
REQ-024 SHALL drive busy high exactly in LOAD and DONE, as a registered state decode.
REQ-025 SHALL drive all outputs from registers, with no combinational path from inputs to outputs.

Reset
REQ-026 SHALL, on rst_n low, immediately set state=IDLE, op=16'h0000, idx=0, busy=0 and frame_done=0, independent of clk.
REQ-027 SHALL, when reset occurs mid-frame, discard the partial frame and generate no frame_done.
REQ-028 SHALL sample inputs on the first clk edge after rst_n deasserts.

Structure
REQ-029 SHALL take the state enumeration, N_OUT=16 and IDX_W=4 from a shared package, demux_pkg.
REQ-030 SHALL instantiate one sub-module, dec_4_16: a combinational 4-to-16 one-hot decoder with an enable input, which generates the per-bit write enables from s or idx.

Verification
REQ-031 SHALL cover: mode=0, wr_en=1, s=9, din=1 -> op=16'h0200 one cycle later; then s=9, din=0 -> op=16'h0000.
REQ-032 SHALL cover: mode=1, start pulse, then 16 cycles of wr_en=1 with din pattern 16'hA5C3 LSB first -> op=16'hA5C3; frame_done high exactly one cycle after the 16th write; busy high for 17 cycles.
REQ-033 SHALL cover: auto frame with wr_en low for 3 cycles after bit 4 -> idx holds at 5, op is unchanged during the stall, and the final op is correct.
REQ-034 SHALL cover: rst_n pulled low after 8 auto bits -> op=0, idx=0 and busy=0 asynchronously; no frame_done follows.
REQ-035 SHALL cover: start and wr_en high in the same IDLE cycle, with din=1 and op previously 16'hFFFF and CLEAR_ON_START=1 -> op=0 and idx=0; no bit is written.
REQ-036 SHALL cover: start asserted during LOAD, and mode toggled during LOAD -> no effect on idx, op or frame timing.

Source files
------------

// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared types and sizes for the one_sixteen_demux block:
//               FSM state enumeration, output count, index width and a
//               helper that merges one routed bit into the output vector.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

  localparam int N_OUT = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Replace the bits selected by the one-hot write mask with din; every
  // other bit keeps its old value.
  function automatic logic [N_OUT-1:0] merge_bit(
    input logic [N_OUT-1:0] old_bits,
    input logic [N_OUT-1:0] we_mask,
    input logic             din
  );
    return (old_bits & ~we_mask) | ({N_OUT{din}} & we_mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dec_4_16.sv
`default_nettype none
// ============================================================================
// Module      : dec_4_16
// Description : Combinational 4-to-16 one-hot decoder with enable. Produces
//               the per-bit write enables for the demux output register.
// Ports       : en     - decoder enable; all outputs low when en=0
//               sel    - 4-bit index to decode
//               onehot - 16-bit one-hot result
// Revision    : 1.0 - initial release
// ============================================================================
module dec_4_16
  import demux_pkg::*;
(
  input  logic             en,
  input  logic [IDX_W-1:0] sel,
  output logic [N_OUT-1:0] onehot
);

  for (genvar i = 0; i < N_OUT; i++) begin : g_bit
    assign onehot[i] = en && (sel == IDX_W'(i));
  end

endmodule
`default_nettype wire

// File: rtl/one_sixteen_demux.sv
`default_nettype none
// ============================================================================
// Module      : one_sixteen_demux
// Description : 1-to-16 registered demultiplexer. In addressed mode a
//               strobed bit lands on op[s]; in auto mode a start pulse opens
//               a 16-bit frame that is filled LSB first on each wr_en, then a
//               one-cycle frame_done pulse is issued.
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               din        - data bit to route
//               s          - destination index (addressed mode)
//               wr_en      - write strobe
//               mode       - 0 addressed, 1 auto-sequenced
//               start      - frame start pulse (auto mode, IDLE only)
//               op         - registered demux outputs
//               busy       - high in LOAD and DONE
//               frame_done - one-cycle pulse after the 16th write
//               idx        - current auto-sequence write index
// Revision    : 1.0 - initial release
// ============================================================================
module one_sixteen_demux
  import demux_pkg::*;
#(
  parameter int CLEAR_ON_START = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic [IDX_W-1:0] s,
  input  logic             wr_en,
  input  logic             mode,
  input  logic             start,
  output logic [N_OUT-1:0] op,
  output logic             busy,
  output logic             frame_done,
  output logic [IDX_W-1:0] idx
);

  state_t           state_q, state_d;
  logic [N_OUT-1:0] op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  logic             dec_en;
  logic [IDX_W-1:0] dec_sel;
  logic [N_OUT-1:0] dec_we;

  // The decoder only fires for a real data write: an addressed write in
  // IDLE, or any strobe during LOAD. A start cycle never enables it, so
  // start always wins over a coincident wr_en.
  assign dec_en  = ((state_q == ST_IDLE) && !mode && wr_en) ||
                   ((state_q == ST_LOAD) && wr_en);
  assign dec_sel = (state_q == ST_LOAD) ? idx_q : s;

  dec_4_16 u_dec (
    .en     (dec_en),
    .sel    (dec_sel),
    .onehot (dec_we)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (mode && start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          if (CLEAR_ON_START != 0) begin
            op_d = '0;
          end
        end else if (dec_en) begin
          op_d = merge_bit(op_q, dec_we, din);
        end
      end
      ST_LOAD: begin
        if (wr_en) begin
          op_d  = merge_bit(op_q, dec_we, din);
          // Natural 4-bit wrap brings idx back to 0 after the last bit.
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_W'(N_OUT - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are decoded from the next state so they are registered
    // alongside the state itself and line up with it cycle for cycle.
    busy_d       = (state_d == ST_LOAD) || (state_d == ST_DONE);
    frame_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign op         = op_q;
  assign idx        = idx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_one_sixteen_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_one_sixteen_demux
// Description : Self-checking bench for one_sixteen_demux. Each driven cycle
//               pushes the expected post-edge outputs into a scoreboard
//               queue; each scenario task pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_one_sixteen_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic [3:0]  s = 4'd0;
  logic        wr_en = 1'b0;
  logic        mode = 1'b0;
  logic        start = 1'b0;
  logic [15:0] op;
  logic        busy;
  logic        frame_done;
  logic [3:0]  idx;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] op;
    logic [3:0]  idx;
    logic        busy;
    logic        fd;
  } exp_t;

  exp_t sb[$];

  // Reference model state (0 idle, 1 load, 2 done)
  int          m_st  = 0;
  logic [15:0] m_op  = 16'h0;
  logic [3:0]  m_idx = 4'd0;

  one_sixteen_demux #(.CLEAR_ON_START(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .s          (s),
    .wr_en      (wr_en),
    .mode       (mode),
    .start      (start),
    .op         (op),
    .busy       (busy),
    .frame_done (frame_done),
    .idx        (idx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, advance the model, push the expectation and
  // step to just after the clock edge.
  task automatic cycle(input logic d, input logic [3:0] sv, input logic w,
                       input logic m, input logic st);
    exp_t e;
    din = d; s = sv; wr_en = w; mode = m; start = st;
    case (m_st)
      0: begin
        if (m && st) begin
          m_st = 1; m_idx = 4'd0; m_op = 16'h0;
        end else if (!m && w) begin
          m_op[sv] = d;
        end
      end
      1: begin
        if (w) begin
          m_op[m_idx] = d;
          if (m_idx == 4'd15) m_st = 2;
          m_idx = m_idx + 4'd1;
        end
      end
      default: m_st = 0;
    endcase
    e.op = m_op; e.idx = m_idx; e.busy = (m_st != 0); e.fd = (m_st == 2);
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({op, idx, busy, frame_done} !== 22'h0) begin
      errors++;
      $display("FAIL reset_state: op=%h idx=%0d busy=%b fd=%b, want all zero",
               op, idx, busy, frame_done);
    end
    rst_n = 1'b1;
    m_st = 0; m_op = 16'h0; m_idx = 4'd0;
  endtask

  task automatic test_addressed;
    exp_t e;
    cycle(1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (op !== 16'h0200 || {op, idx, busy, frame_done} !== e) begin
      errors++;
      $display("FAIL addr_s9_set: op=%h idx=%0d busy=%b fd=%b, want op=0200 (model %h)",
               op, idx, busy, frame_done, e.op);
    end
    cycle(1'b0, 4'd9, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (op !== 16'h0000 || {op, idx, busy, frame_done} !== e) begin
      errors++;
      $display("FAIL addr_s9_clear: op=%h, want 0000", op);
    end
    // Edge indices, hold on wr_en=0, start ignored in mode 0, wr_en
    // ignored in idle mode 1.
    cycle(1'b1, 4'd0,  1'b1, 1'b0, 1'b0);
    cycle(1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 4'd0,  1'b0, 1'b0, 1'b0);
    cycle(1'b0, 4'd15, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 4'd4,  1'b1, 1'b1, 1'b0);
    cycle(1'b0, 4'd0,  1'b1, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if ({op, idx, busy, frame_done} !== e && sb.size() == 0) begin
        errors++;
        $display("FAIL addr_seq: op=%h idx=%0d busy=%b fd=%b, want op=%h idx=%0d busy=%b fd=%b",
                 op, idx, busy, frame_done, e.op, e.idx, e.busy, e.fd);
      end
    end
    checks++;
    if (op !== 16'h0000) begin
      errors++;
      $display("FAIL addr_final: op=%h, want 0000", op);
    end
  endtask

  task automatic test_auto_frame(input logic [15:0] pat);
    exp_t e;
    int   busy_cnt = 0;
    int   fd_cnt   = 0;
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    e = sb.pop_front(); checks++;
    if ({op, idx, busy, frame_done} !== e) begin
      errors++;
      $display("FAIL auto_start: op=%h idx=%0d busy=%b, want op=%h idx=%0d busy=%b",
               op, idx, busy, e.op, e.idx, e.busy);
    end
    busy_cnt += int'(busy);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) cycle(pat[i], 4'($urandom_range(15)), 1'b1, 1'b1, 1'b0);
      else        cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front(); checks++;
      busy_cnt += int'(busy);
      fd_cnt   += int'(frame_done);
      if ({op, idx, busy, frame_done} !== e) begin
        errors++;
        $display("FAIL auto_bit%0d: op=%h idx=%0d busy=%b fd=%b, want op=%h idx=%0d busy=%b fd=%b",
                 i, op, idx, busy, frame_done, e.op, e.idx, e.busy, e.fd);
      end
      if (i == 15) begin
        checks++;
        if (op !== pat || frame_done !== 1'b1) begin
          errors++;
          $display("FAIL auto_done: op=%h fd=%b, want op=%h fd=1", op, frame_done, pat);
        end
      end
    end
    checks++;
    if (busy_cnt != 17 || fd_cnt != 1) begin
      errors++;
      $display("FAIL auto_counts: busy=%0d fd=%0d cycles, want 17 and 1", busy_cnt, fd_cnt);
    end
  endtask

  task automatic test_stall;
    exp_t        e;
    logic [15:0] pat = 16'h3C5A;
    logic [15:0] snap;
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      cycle(pat[i], 4'd0, 1'b1, 1'b1, 1'b0);
      void'(sb.pop_front());
    end
    snap = op;
    for (int k = 0; k < 3; k++) begin
      cycle(1'($urandom_range(1)), 4'd7, 1'b0, 1'b1, 1'b0);
      e = sb.pop_front(); checks++;
      if (idx !== 4'd5 || op !== snap || {op, idx, busy, frame_done} !== e) begin
        errors++;
        $display("FAIL stall%0d: idx=%0d op=%h, want idx=5 op=%h", k, idx, op, snap);
      end
    end
    for (int i = 5; i < 16; i++) begin
      cycle(pat[i], 4'd0, 1'b1, 1'b1, 1'b0);
      e = sb.pop_front();
    end
    checks++;
    if (op !== pat || frame_done !== 1'b1 || {op, idx, busy, frame_done} !== e) begin
      errors++;
      $display("FAIL stall_final: op=%h fd=%b, want op=%h fd=1", op, frame_done, pat);
    end
    cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
  endtask

  task automatic test_reset_midframe;
    exp_t e;
    int   fd_seen = 0;
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    void'(sb.pop_front());
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
      void'(sb.pop_front());
    end
    // Assert reset between edges: outputs must clear without a clock.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({op, idx, busy, frame_done} !== 22'h0) begin
      errors++;
      $display("FAIL async_reset: op=%h idx=%0d busy=%b fd=%b, want all zero",
               op, idx, busy, frame_done);
    end
    m_st = 0; m_op = 16'h0; m_idx = 4'd0;
    sb.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
      e = sb.pop_front();
      fd_seen += int'(frame_done);
      if ({op, idx, busy, frame_done} !== e) fd_seen += 100;
    end
    checks++;
    if (fd_seen != 0) begin
      errors++;
      $display("FAIL reset_no_done: score=%0d, want 0 (no frame_done, idle)", fd_seen);
    end
  endtask

  task automatic test_start_wins;
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
      void'(sb.pop_front());
    end
    checks++;
    if (op !== 16'hFFFF) begin
      errors++;
      $display("FAIL fill_ffff: op=%h, want ffff", op);
    end
    cycle(1'b1, 4'd3, 1'b1, 1'b1, 1'b1);
    e = sb.pop_front(); checks++;
    if (op !== 16'h0000 || idx !== 4'd0 || {op, idx, busy, frame_done} !== e) begin
      errors++;
      $display("FAIL start_wins: op=%h idx=%0d busy=%b, want op=0000 idx=0 busy=1",
               op, idx, busy);
    end
    for (int i = 0; i < 17; i++) begin
      cycle(1'b0, 4'd0, (i < 16), 1'b1, 1'b0);
      void'(sb.pop_front());
    end
  endtask

  task automatic test_ignore_in_load;
    exp_t        e;
    logic [15:0] pat = 16'h96E1;
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    void'(sb.pop_front());
    for (int i = 0; i < 16; i++) begin
      cycle(pat[i], 4'($urandom_range(15)), 1'b1, 1'(i % 2), 1'b1);
      e = sb.pop_front(); checks++;
      if ({op, idx, busy, frame_done} !== e) begin
        errors++;
        $display("FAIL load_ignore%0d: op=%h idx=%0d busy=%b fd=%b, want op=%h idx=%0d busy=%b fd=%b",
                 i, op, idx, busy, frame_done, e.op, e.idx, e.busy, e.fd);
      end
    end
    checks++;
    if (op !== pat || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL load_ignore_final: op=%h fd=%b, want op=%h fd=1", op, frame_done, pat);
    end
    // DONE returns to IDLE even with start held high.
    cycle(1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    e = sb.pop_front(); checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || {op, idx, busy, frame_done} !== e) begin
      errors++;
      $display("FAIL done_exit: busy=%b fd=%b, want busy=0 fd=0", busy, frame_done);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_addressed();
    test_auto_frame(16'hA5C3);
    test_stall();
    test_reset_midframe();
    test_start_wins();
    test_ignore_in_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
